// File: rtl/if_row_tag_fifo_pkg.sv
// Shared definitions for the IF row-tagging FIFO.
// Tag bit positions are functions of the data width, so each user derives them
// from its own DATA_WIDTH parameter.
package if_row_tag_fifo_pkg;

  localparam int unsigned IF_DATA_WIDTH_DFLT = 8;

  // Per-word row tags, packed in the order they sit above the data field.
  typedef struct packed {
    logic start_flag;
    logic end_flag;
  } if_tag_t;

  function automatic int unsigned if_tag_end_bit(input int unsigned data_width);
    return data_width;
  endfunction

  function automatic int unsigned if_tag_start_bit(input int unsigned data_width);
    return data_width + 1;
  endfunction

  function automatic int unsigned if_tagged_width(input int unsigned data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/if_row_tag_fifo_core.sv
// Synchronous show-ahead FIFO core: storage, pointers, occupancy count,
// full/empty flags and a zero-forced read word while empty.
module tagged_sync_fifo_core #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             push_ok,
  output logic             pop_ok
);

  localparam logic [ADDR_LEN:0] FullCount = (ADDR_LEN + 1)'(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [ADDR_LEN-1:0] wptr_q;
  logic [ADDR_LEN-1:0] rptr_q;
  logic [ADDR_LEN:0]   count_q;

  // Flags come from the registered count; clr suppresses both operations.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FullCount);
    push_ok = push && !full && !clr;
    pop_ok  = pop && !empty && !clr;
    rdata   = empty ? '0 : mem_q[rptr_q];
  end

  // Storage array; no reset needed because reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_row_tag_fifo.sv
// IF input buffer: tags the first/last word of each row and presents a
// show-ahead word to the PE scratch-pad reader.
// Optional macro IF_ROW_TAG_FIFO_ROW_CNT_EN adds rows_pending, the number of
// complete rows currently held.
module if_row_tag_fifo
  import if_row_tag_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = IF_DATA_WIDTH_DFLT,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDR_LEN      = 4,
  parameter int unsigned ROW_LEN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [ROW_LEN_WIDTH-1:0] row_len,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  input  logic                     buf_read,
  output logic                     buf_empty,
  output logic                     buf_full,
  output logic [DATA_WIDTH+1:0]    buf_dout
`ifdef IF_ROW_TAG_FIFO_ROW_CNT_EN
  ,
  output logic [ADDR_LEN:0]        rows_pending
`endif
);

  localparam int unsigned IF_TAG_END_BIT   = if_tag_end_bit(DATA_WIDTH);
  localparam int unsigned IF_TAG_START_BIT = if_tag_start_bit(DATA_WIDTH);
  localparam int unsigned IF_TAGGED_WIDTH  = if_tagged_width(DATA_WIDTH);

  logic [ROW_LEN_WIDTH-1:0]   elem_cnt_q;
  logic [ROW_LEN_WIDTH-1:0]   latched_len_q;
  logic [ROW_LEN_WIDTH-1:0]   eff_len;
  logic [ROW_LEN_WIDTH-1:0]   row_last;
  if_tag_t                    tag;
  logic [IF_TAGGED_WIDTH-1:0] wdata;
  logic                       push_ok;
  logic                       pop_ok;

  // Row tag for the word being offered; the first word of a row uses the live
  // row_len, later words use the length latched at the row start.
  always_comb begin
    eff_len        = (row_len == '0) ? ROW_LEN_WIDTH'(1) : row_len;
    row_last       = (elem_cnt_q == '0) ? eff_len - ROW_LEN_WIDTH'(1)
                                        : latched_len_q - ROW_LEN_WIDTH'(1);
    tag.start_flag = (elem_cnt_q == '0);
    tag.end_flag   = (elem_cnt_q == row_last);
    wdata          = {tag, in_data};
  end

  assign in_ready = ~buf_full;

  tagged_sync_fifo_core #(
    .WIDTH    (IF_TAGGED_WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_LEN (ADDR_LEN)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (in_valid),
    .pop     (buf_read),
    .wdata   (wdata),
    .rdata   (buf_dout),
    .empty   (buf_empty),
    .full    (buf_full),
    .push_ok (push_ok),
    .pop_ok  (pop_ok)
  );

  // Element counter and row-length latch; wraps after the row's last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt_q    <= '0;
      latched_len_q <= '0;
    end else if (clr) begin
      elem_cnt_q    <= '0;
      latched_len_q <= '0;
    end else if (push_ok) begin
      if (tag.start_flag) begin
        latched_len_q <= eff_len;
      end
      elem_cnt_q <= tag.end_flag ? '0 : elem_cnt_q + ROW_LEN_WIDTH'(1);
    end
  end

`ifdef IF_ROW_TAG_FIFO_ROW_CNT_EN
  logic row_in;
  logic row_out;

  assign row_in  = push_ok && tag.end_flag;
  assign row_out = pop_ok && buf_dout[IF_TAG_END_BIT];

  // Complete-row counter: one per resident end-tagged word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_pending <= '0;
    end else if (clr) begin
      rows_pending <= '0;
    end else begin
      case ({row_in, row_out})
        2'b10:   rows_pending <= rows_pending + 1'b1;
        2'b01:   rows_pending <= rows_pending - 1'b1;
        default: rows_pending <= rows_pending;
      endcase
    end
  end
`else
  // Row counter not built.
`endif

endmodule

// File: doc/if_row_tag_fifo.md
Name: if_row_tag_fifo

Overview:
Input-feature buffer feeding the PE's IF scratch-pad reader, placed directly upstream of the PE datapath's IF buffer port.
- Accepts raw IF words from the global-buffer side through a valid/ready handshake.
- Tags the first and last word of each row with start and end flags.
- Presents a show-ahead (first-word-fall-through) word plus an empty flag to the PE's read/empty handshake.

Parameters:
DATA_WIDTH, 8, IF element width (equals IF scratch width).
DEPTH, 16, FIFO entries; power of two, at least 2.
ADDR_LEN, 4, log2(DEPTH).
ROW_LEN_WIDTH, 8, width of the row-length input.

Ports:
clk  in  1  clock
rst  in  1  reset: asynchronous, active-high
clr  in  1  synchronous flush
row_len  in  ROW_LEN_WIDTH  elements per row
in_valid  in  1  producer word valid
in_data  in  DATA_WIDTH  producer word
in_ready  out  1  FIFO can accept a word
buf_read  in  1  consumer pop request
buf_empty  out  1  no word available
buf_full  out  1  DEPTH words stored
buf_dout  out  DATA_WIDTH+2  {start_flag, end_flag, data}; bit DATA_WIDTH = end, bit DATA_WIDTH+1 = start

Behaviour:
- Reset/clr state:
  - wptr, rptr, count and elem_cnt are 0.
  - buf_empty=1, buf_full=0, in_ready=1, buf_dout=0.
  - clr has priority over a push or pop in the same cycle.
  - rst mid-row discards the partial row; the next push is the first word of a new row.
- Push:
  - A push occurs when in_valid && in_ready, with in_ready = ~buf_full.
  - buf_full and buf_empty derive from the registered count (0..DEPTH, ADDR_LEN+1 bits).
  - Word written to mem[wptr] = {elem_cnt==0, elem_cnt==row_last, in_data}.
  - wptr increments modulo DEPTH.
- Row tagging:
  - row_last = latched_len-1.
  - latched_len is captured from row_len on the push with elem_cnt==0; row_len changes mid-row are ignored.
  - row_len==0 is treated as 1.
  - elem_cnt increments on each push and wraps to 0 after the push with elem_cnt==row_last.
  - With row_len==1, every word carries start=1 and end=1.
- Pop:
  - A pop occurs when buf_read && ~buf_empty.
  - rptr increments modulo DEPTH.
  - buf_read while empty is ignored, with no pointer or count change.
- Output: buf_dout = mem[rptr], combinational show-ahead; it is forced to 0 while buf_empty.
- Latency: a word pushed in cycle N is visible on buf_dout, with buf_empty=0, in cycle N+1.
- Simultaneous push and pop:
  - Both allowed while not full and not empty; count is unchanged.
  - When full: push blocked (in_ready=0), pop proceeds, and in_ready rises next cycle.
  - When empty: pop ignored, push proceeds.
- No overflow or underflow is possible under the handshake; count never exceeds DEPTH.

Optional Feature:
- Macro IF_ROW_TAG_FIFO_ROW_CNT_EN.
- Defined:
  - Adds output rows_pending [ADDR_LEN:0], a count of complete rows held in the FIFO (reset/clr value 0).
  - It increments on a push whose end flag is 1 and decrements on a pop of a word whose end flag is 1.
  - Both in the same cycle leave it unchanged.
  - The controller uses it to start an IF read only when a whole row is resident.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Bit-position constants IF_TAG_END_BIT = DATA_WIDTH and IF_TAG_START_BIT = DATA_WIDTH+1, expressed as parameter-relative localparams.
  - The tagged-word width DATA_WIDTH+2.
- One natural sub-module, tagged_sync_fifo_core: storage, pointers, count, full/empty and show-ahead read.
- The row tagger (elem_cnt, latched_len) and the optional row counter stay in the top.

Test Plan:
- row_len=3, push 6 words 0x11..0x16 with no reads → entries {start,end} = 10,00,01,10,00,01; buf_dout after first push = {1,0,0x11}.
- row_len=1, push 0xA5 → buf_dout = {1,1,0xA5}; buf_read pops it → buf_empty=1 next cycle, buf_dout=0.
- Push 16 words → buf_full=1, in_ready=0, and a 17th in_valid is not stored; one pop with in_valid held → in_ready=1 next cycle, 17th word stored, count=16.
- Empty FIFO with buf_read=1 and a push of 0x3C in the same cycle → count=1, buf_dout=0x3C with start tag; pointers are not corrupted.
- row_len=4, push 2 words, assert clr, then push with row_len=2 → next word start=1 and the second word end=1; the old data is gone.
- Macro on, row_len=2, push 5 words → rows_pending=2; pop 2 words → rows_pending=1; assert rst mid-stream → rows_pending=0 immediately.
